// File: rtl/sc_mul_normalize.sv
// sc_mul_normalize
// Post-processing for the stochastic-computing FP32 multiplier. Takes the
// ones-count of the 255-cycle AND-bitstream plus the original operands,
// renormalises the 8-bit mantissa count, forms and range-checks the exponent,
// resolves IEEE special cases and returns a packed FP32 product (7-bit
// truncated mantissa, low 16 bits zero) through a valid/ready handshake.
//
// The count represents p = count/256 with (1.ma)(1.mb) = 4p, so a count of
// 64 is a product of exactly 1.0. Normalisation shifts left until bit 6 or 7
// is set. Bit 7 means the product is in [2,4) and bumps the exponent.

module sc_mul_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [7:0]  count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Captured operands without their sign bits; the product sign is kept separately.
    logic [30:0]       a_mag;
    logic [30:0]       b_mag;
    logic [7:0]        m;
    logic              sign;
    logic signed [9:0] e;
    logic [31:0]       p_reg;

    logic              special;
    logic              norm_stop;

    // Biased exponent sum: ea + eb - 127, wide enough for 254+254-127+1.
    function automatic logic signed [9:0] exp_sum(input logic [7:0] ea,
                                                  input logic [7:0] eb);
        logic signed [9:0] sum;
        sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        return sum;
    endfunction

    // Special-case resolution, mantissa extraction and exponent saturation.
    function automatic logic [31:0] pack_result(input logic [30:0]       fa,
                                                input logic [30:0]       fb,
                                                input logic              s,
                                                input logic signed [9:0] ex,
                                                input logic [7:0]        mm);
        logic [31:0]       res;
        logic              a_inf;
        logic              b_inf;
        logic              a_zero;
        logic              b_zero;
        logic              a_nan;
        logic              b_nan;
        logic signed [9:0] e_adj;
        logic [6:0]        mant;

        a_inf  = (fa[30:23] == 8'hFF);
        b_inf  = (fb[30:23] == 8'hFF);
        a_zero = (fa[30:23] == 8'h00);
        b_zero = (fb[30:23] == 8'h00);
        a_nan  = a_inf && (fa[22:0] != 23'd0);
        b_nan  = b_inf && (fb[22:0] != 23'd0);

        if (mm[7]) begin
            e_adj = ex + 10'sd1;
            mant  = mm[6:0];
        end else begin
            e_adj = ex;
            mant  = {mm[5:0], 1'b0};
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            res = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero || (mm == 8'd0)) begin
            res = {s, 31'd0};
        end else if (e_adj >= 10'sd255) begin
            res = {s, 8'hFF, 23'd0};
        end else if (e_adj <= 10'sd0) begin
            res = {s, 31'd0};
        end else begin
            res = {s, e_adj[7:0], mant, 16'd0};
        end
        return res;
    endfunction

    // Decide when normalisation is finished and flag operands that bypass it.
    always_comb begin
        special   = 1'b0;
        norm_stop = 1'b0;
        special   = (a_mag[30:23] == 8'hFF) || (a_mag[30:23] == 8'h00) ||
                    (b_mag[30:23] == 8'hFF) || (b_mag[30:23] == 8'h00);
        norm_stop = special || (m == 8'd0) || m[7] || m[6];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        p_out     = p_reg;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (norm_stop) begin
                    state_nx = PACK;
                end
            end
            PACK: begin
                state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, normalisation shifts and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag <= '0;
            b_mag <= '0;
            m     <= '0;
            sign  <= 1'b0;
            e     <= '0;
            p_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_mag <= a[30:0];
                        b_mag <= b[30:0];
                        m     <= count;
                        sign  <= a[31] ^ b[31];
                        e     <= exp_sum(a[30:23], b[30:23]);
                    end
                end
                NORM: begin
                    if (!norm_stop) begin
                        m <= {m[6:0], 1'b0};
                        e <= e - 10'sd1;
                    end
                end
                PACK: begin
                    p_reg <= pack_result(a_mag, b_mag, sign, e, m);
                end
                OUT: begin
                    // Clear on handshake so p_out reads zero outside OUT.
                    if (out_ready) begin
                        p_reg <= '0;
                    end
                end
                default: begin
                    p_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mul_normalize.sv
// Testbench for sc_mul_normalize: directed cases followed by randomized
// operations, each checked against an arithmetic reference model.

module tb_sc_mul_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sc_mul_normalize dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_out     (p_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: product value is (count/64) * 2^(ea+eb-254); normalise by
    // locating the leading one of count, then truncate to 7 fraction bits.
    function automatic void ref_model(input logic [31:0] fa, input logic [31:0] fb,
                                      input logic [7:0] cnt,
                                      output logic [31:0] res, output int shifts);
        int ea, eb, ex, msb, mv, frac;
        logic sgn;
        ea = int'(fa[30:23]);
        eb = int'(fb[30:23]);
        sgn = fa[31] ^ fb[31];
        shifts = 0;
        if ((ea == 255 && fa[22:0] != 0) || (eb == 255 && fb[22:0] != 0) ||
            (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
            res = 32'h7FC0_0000;
            return;
        end
        if (ea == 255 || eb == 255) begin
            res = {sgn, 8'hFF, 23'd0};
            return;
        end
        if (ea == 0 || eb == 0 || cnt == 0) begin
            res = {sgn, 31'd0};
            return;
        end
        msb = 0;
        for (int i = 0; i < 8; i++) if (cnt[i]) msb = i;
        mv = int'(cnt);
        ex = ea + eb - 127;
        if (msb < 6) begin
            shifts = 6 - msb;
            mv = mv * (1 << shifts);
            ex = ex - shifts;
        end
        if (mv >= 128) begin
            ex = ex + 1;
            frac = mv - 128;
        end else begin
            frac = (mv - 64) * 2;
        end
        if (ex >= 255)      res = {sgn, 8'hFF, 23'd0};
        else if (ex <= 0)   res = {sgn, 31'd0};
        else                res = {sgn, ex[7:0], frac[6:0], 16'd0};
    endfunction

    // One full operation: transfer, bounded wait for result, optional
    // back-pressure hold, then handshake and return to idle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic [7:0] tc, input int hold);
        logic [31:0] exp_p;
        int          s;
        int          cyc;
        ref_model(ta, tb, tc, exp_p, s);
        a = ta;
        b = tb;
        count = tc;
        in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        // Keep in_valid high with different data: must be ignored while busy.
        a = ~ta;
        b = 32'h3F80_0000;
        count = ~tc;
        cyc = 0;
        while (!out_valid && cyc < 12) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        check("latency", cyc, 2 + s);
        check("p_out", p_out, exp_p);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_p_out", p_out, exp_p);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_p_out", p_out, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  rc;
        logic [31:0] spec_vals [6];

        spec_vals[0] = 32'h7F80_0000;
        spec_vals[1] = 32'hFF80_0000;
        spec_vals[2] = 32'h7FC1_2345;
        spec_vals[3] = 32'h0000_0000;
        spec_vals[4] = 32'h8000_0000;
        spec_vals[5] = 32'h0012_3456;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        count = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_p_out", p_out, 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(32'h3F80_0000, 32'h3F80_0000, 8'd64, 0);
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 8'd144, 0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 8'd8, 0);
        run_op(32'h7F80_0000, 32'h0000_0000, 8'd64, 0);
        run_op(32'hFF80_0000, 32'h3F80_0000, 8'd64, 0);
        run_op(32'h8000_0000, 32'h4000_0000, 8'd64, 0);
        run_op(32'h7F00_0000, 32'h7F00_0000, 8'd64, 0);
        run_op(32'h0080_0000, 32'h0080_0000, 8'd64, 0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 8'd0, 0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 8'd1, 0);
        run_op(32'h4000_0000, 32'hC000_0000, 8'd200, 10);

        // Reset during NORM of a count=1 operation.
        a = 32'h3F80_0000;
        b = 32'h3F80_0000;
        count = 8'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_p_out", p_out, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) begin
            @(posedge clk); #1;
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(32'h3FC0_0000, 32'h3F80_0000, 8'd96, 0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 8'($urandom_range(0, 255));
            if (n % 4 != 3) begin
                ra[30:23] = 8'($urandom_range(90, 164));
                rb[30:23] = 8'($urandom_range(90, 164));
            end
            if (n % 7 == 5) ra = spec_vals[$urandom_range(0, 5)];
            if (n % 11 == 6) rb = spec_vals[$urandom_range(0, 5)];
            run_op(ra, rb, rc, (n % 9 == 0) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
